tim_port_arbiter: RTL

TIM_PORT_ARBITER -- requirements
Module: tim_port_arbiter

---
 rtl/tim_port_arbiter_pkg.sv | 26 ++
 rtl/tim_port_arbiter_rr_pick4.sv | 21 ++
 rtl/tim_port_arbiter.sv | 110 +++++++++++
 3 files changed

// File: rtl/tim_port_arbiter_pkg.sv
// Shared bus types for TIM accesses and the arbiter's configuration defaults.
package wires;

  typedef struct packed {
    logic        mem_valid;
    logic [31:0] mem_addr;
    logic [31:0] mem_wdata;
    logic [3:0]  mem_wstrb;
  } mem_in_type;

  typedef struct packed {
    logic        mem_ready;
    logic [31:0] mem_rdata;
    logic        mem_error;
  } mem_out_type;

  localparam mem_in_type  init_mem_in  = '0;
  localparam mem_out_type init_mem_out = '0;

endpackage

package configure;

  localparam int tim_arb_timeout = 1023;

endpackage

// File: rtl/tim_port_arbiter_rr_pick4.sv
// Combinational round-robin picker: first set request bit after ptr, wrapping.
module rr_pick4 (
  input  logic [3:0] req,
  input  logic [1:0] ptr,
  output logic [1:0] grant,
  output logic       valid
);

  // k=4 wraps to ptr itself, so the last-granted port is searched last
  always_comb begin
    grant = '0;
    valid = 1'b0;
    for (int k = 1; k <= 4; k++) begin
      if (!valid && req[ptr + 2'(k)]) begin
        grant = ptr + 2'(k);
        valid = 1'b1;
      end
    end
  end

endmodule

// File: rtl/tim_port_arbiter.sv
// Four-port round-robin arbiter in front of a single-port TIM bank, with one
// pending slot per port and a response timeout that synthesises an error.
module tim_port_arbiter
  import wires::*;
  import configure::*;
#(
  parameter int timeout_cycles = tim_arb_timeout
) (
  input  logic        reset,
  input  logic        clock,
  input  mem_in_type  req_in  [0:3],
  output mem_out_type req_out [0:3],
  output mem_in_type  mem_in,
  input  mem_out_type mem_out
);

  localparam int             TW     = $clog2(timeout_cycles) + 1;
  localparam logic [TW-1:0]  T_LAST = TW'(timeout_cycles - 1);

  typedef enum logic {IDLE, BUSY} state_t;

  state_t        state, state_next;
  logic [3:0]    pend, live, cand, capture;
  mem_in_type    pend_req [0:3];
  logic [1:0]    owner, ptr, gnt;
  logic          gnt_valid;
  logic [TW-1:0] timer;

  always_comb begin
    live = '0;
    for (int i = 0; i < 4; i++) live[i] = req_in[i].mem_valid;
  end

  assign cand = (state == IDLE) ? (pend | live) : 4'b0000;

  rr_pick4 u_pick (
    .req   (cand),
    .ptr   (ptr),
    .grant (gnt),
    .valid (gnt_valid)
  );

  // A pulse is dropped if its port already has a pending or in-flight request
  always_comb begin
    capture = '0;
    for (int i = 0; i < 4; i++) begin
      capture[i] = live[i] && !pend[i]
                   && !(state == BUSY && owner == 2'(i))
                   && !(gnt_valid && gnt == 2'(i));
    end
  end

  always_comb begin
    state_next = state;
    mem_in     = init_mem_in;
    for (int i = 0; i < 4; i++) req_out[i] = init_mem_out;
    if (reset) begin
      case (state)
        IDLE: begin
          if (gnt_valid) begin
            state_next = BUSY;
            mem_in     = pend[gnt] ? pend_req[gnt] : req_in[gnt];
          end
        end
        BUSY: begin
          if (mem_out.mem_ready) begin
            state_next     = IDLE;
            req_out[owner] = mem_out;
          end else if (timer == T_LAST) begin
            state_next     = IDLE;
            req_out[owner] = '{mem_ready: 1'b1, mem_rdata: 32'h0, mem_error: 1'b1};
          end
        end
        default: state_next = IDLE;
      endcase
    end
  end

  always_ff @(posedge clock) begin
    if (!reset) state <= IDLE;
    else        state <= state_next;
  end

  // Pending slots, ownership and the timeout counter
  always_ff @(posedge clock) begin
    if (!reset) begin
      pend  <= '0;
      owner <= 2'd0;
      ptr   <= 2'd3;
      timer <= '0;
      for (int i = 0; i < 4; i++) pend_req[i] <= init_mem_in;
    end else begin
      for (int i = 0; i < 4; i++) begin
        if (capture[i]) begin
          pend[i]     <= 1'b1;
          pend_req[i] <= req_in[i];
        end
      end
      if (state == IDLE && gnt_valid) begin
        owner     <= gnt;
        ptr       <= gnt;
        pend[gnt] <= 1'b0;
        timer     <= '0;
      end else if (state == BUSY && state_next == BUSY) begin
        timer <= timer + 1'b1;
      end
    end
  end

endmodule
